// File: rtl/frame_max_tracker_if.sv
`default_nettype none
// ============================================================================
// Module      : frame_max_tracker_if
// Description : Bundles the sample-in handshake, the external comparator
//               link and the frame-result handshake of frame_max_tracker.
//               slave  - the tracker block itself
//               master - the environment (producer, comparator, consumer)
// Ports       : in_valid/in_ready/in_data    sample stream
//               cmp_a/cmp_b                   operands to comparator
//               cmp_less/equal/greater        comparator flags (A vs B)
//               out_valid/out_ready           result handshake
//               out_max/out_idx/out_ties/out_err  frame result
// Revision    : 1.0 - initial release
// ============================================================================
interface frame_max_tracker_if #(
  parameter int IDX_W = 3,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic [7:0]       cmp_a;
  logic [7:0]       cmp_b;
  logic             cmp_less;
  logic             cmp_equal;
  logic             cmp_greater;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_max;
  logic [IDX_W-1:0] out_idx;
  logic [CNT_W-1:0] out_ties;
  logic             out_err;

  modport slave (
    input  in_valid, in_data, cmp_less, cmp_equal, cmp_greater, out_ready,
    output in_ready, cmp_a, cmp_b, out_valid, out_max, out_idx, out_ties, out_err
  );

  modport master (
    output in_valid, in_data, cmp_less, cmp_equal, cmp_greater, out_ready,
    input  in_ready, cmp_a, cmp_b, out_valid, out_max, out_idx, out_ties, out_err
  );
endinterface
`default_nettype wire

// File: rtl/frame_max_tracker.sv
`default_nettype none
// ============================================================================
// Module      : frame_max_tracker
// Description : Tracks the maximum of each fixed-length frame of 8-bit
//               samples using an external magnitude comparator, together with
//               the first index of the maximum, its tie count and a sticky
//               flag for illegal comparator flag encodings. Emits one result
//               per frame over a valid/ready handshake.
// Ports       : clk   - rising-edge clock
//               reset - synchronous active-high reset
//               bus   - frame_max_tracker_if.slave (sample in, comparator
//                       link, result out)
// Revision    : 1.0 - initial release
// ============================================================================
module frame_max_tracker #(
  parameter int FRAME_LEN = 8,
  parameter int IDX_W     = 3,
  parameter int CNT_W     = 4
) (
  input  wire logic         clk,
  input  wire logic         reset,
  frame_max_tracker_if.slave bus
);

  typedef enum logic [1:0] {
    S_FIRST = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] c_last_pos = IDX_W'(FRAME_LEN - 1);

  state_t           r_state;
  logic [7:0]       r_max;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_ties;
  logic             r_err;
  logic [IDX_W-1:0] r_pos;

  logic             r_in_ready;
  logic             r_out_valid;
  logic [7:0]       r_out_max;
  logic [IDX_W-1:0] r_out_idx;
  logic [CNT_W-1:0] r_out_ties;
  logic             r_out_err;

  logic             w_accept;
  logic [7:0]       w_max_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [CNT_W-1:0] w_ties_nxt;
  logic             w_err_nxt;

  assign w_accept = bus.in_valid & r_in_ready;

  // Comparator sees the live sample against the stored maximum.
  assign bus.cmp_a = bus.in_data;
  assign bus.cmp_b = r_max;

  // Next-state of the running statistics for an ACCUM-state accept.
  always_comb begin
    w_max_nxt  = r_max;
    w_idx_nxt  = r_idx;
    w_ties_nxt = r_ties;
    w_err_nxt  = r_err;
    case ({bus.cmp_less, bus.cmp_equal, bus.cmp_greater})
      3'b001: begin
        w_max_nxt  = bus.in_data;
        w_idx_nxt  = r_pos;
        w_ties_nxt = CNT_W'(1);
      end
      3'b010:  w_ties_nxt = r_ties + CNT_W'(1);
      3'b100:  ;
      default: w_err_nxt = 1'b1;  // flags not one-hot: ignore sample, flag it
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_FIRST;
      r_max       <= '0;
      r_idx       <= '0;
      r_ties      <= '0;
      r_err       <= 1'b0;
      r_pos       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_max   <= '0;
      r_out_idx   <= '0;
      r_out_ties  <= '0;
      r_out_err   <= 1'b0;
    end else begin
      case (r_state)
        S_FIRST: begin
          // First sample of a frame seeds the maximum; flags are meaningless
          // here because cmp_b still holds the previous frame's value.
          if (w_accept) begin
            r_max   <= bus.in_data;
            r_idx   <= '0;
            r_ties  <= CNT_W'(1);
            r_err   <= 1'b0;
            r_pos   <= IDX_W'(1);
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_max  <= w_max_nxt;
            r_idx  <= w_idx_nxt;
            r_ties <= w_ties_nxt;
            r_err  <= w_err_nxt;
            if (r_pos == c_last_pos) begin
              // Result registers capture the final statistics on entry to
              // HOLD so they remain stable until the consumer takes them.
              r_out_max   <= w_max_nxt;
              r_out_idx   <= w_idx_nxt;
              r_out_ties  <= w_ties_nxt;
              r_out_err   <= w_err_nxt;
              r_out_valid <= 1'b1;
              r_in_ready  <= 1'b0;
              r_state     <= S_HOLD;
            end else begin
              r_pos <= r_pos + IDX_W'(1);
            end
          end
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_pos       <= '0;
            r_state     <= S_FIRST;
          end
        end
        default: begin
          r_state     <= S_FIRST;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_pos       <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_max   = r_out_max;
  assign bus.out_idx   = r_out_idx;
  assign bus.out_ties  = r_out_ties;
  assign bus.out_err   = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_frame_max_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_max_tracker
// Description : Self-checking bench for frame_max_tracker. Emulates the
//               external comparator (with optional illegal flag injection),
//               drives directed and random frames, and checks results
//               popped from an expected-result queue by a separate monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_max_tracker;

  localparam int FRAME_LEN = 4;
  localparam int IDX_W     = 2;
  localparam int CNT_W     = 3;

  typedef struct packed {
    logic [7:0]       mx;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] ties;
    logic             err;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  frame_max_tracker_if #(.IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

  frame_max_tracker #(
    .FRAME_LEN(FRAME_LEN),
    .IDX_W    (IDX_W),
    .CNT_W    (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int         n_checks = 0;
  int         n_err    = 0;
  logic       force_bad;
  logic [2:0] bad_code;
  logic       rand_ready;
  logic       ready_val;
  logic [2:0] bad_codes [5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

  res_t       exp_q [$];
  logic [7:0] cur_d [$];
  logic       cur_b [$];
  res_t       mon_e;

  // External comparator model, with the option to corrupt the flags.
  always_comb begin
    bus.cmp_less    = 1'b0;
    bus.cmp_equal   = 1'b0;
    bus.cmp_greater = 1'b0;
    if (force_bad) begin
      {bus.cmp_less, bus.cmp_equal, bus.cmp_greater} = bad_code;
    end else begin
      bus.cmp_less    = bus.cmp_a <  bus.cmp_b;
      bus.cmp_equal   = bus.cmp_a == bus.cmp_b;
      bus.cmp_greater = bus.cmp_a >  bus.cmp_b;
    end
  end

  // Consumer readiness: random or held at a chosen level.
  always @(posedge clk) begin
    #2;
    bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Reference: samples whose flags were corrupted (other than the first,
  // whose flags are never looked at) are ignored and mark the frame in error.
  // Result = max of the remaining samples, first position, and its count.
  function automatic res_t model_frame();
    res_t r;
    int   mx = -1;
    r = '0;
    for (int i = 0; i < cur_d.size(); i++)
      if (!(i > 0 && cur_b[i]) && int'(cur_d[i]) > mx) mx = int'(cur_d[i]);
    r.mx = 8'(mx);
    r.idx = '0;
    for (int i = cur_d.size() - 1; i >= 0; i--) begin
      if (i > 0 && cur_b[i]) begin
        r.err = 1'b1;
      end else if (int'(cur_d[i]) == mx) begin
        r.idx  = IDX_W'(i);
        r.ties = r.ties + CNT_W'(1);
      end
    end
    return r;
  endfunction

  // Offer one sample and wait (bounded) until it is accepted.
  task automatic send(input logic [7:0] d, input logic bad, input logic [2:0] code);
    logic got = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    force_bad    = bad;
    bad_code     = code;
    for (int g = 0; g < 100 && !got; g++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        @(posedge clk);
        #1;
        got = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    force_bad    = 1'b0;
    if (!got) begin
      chk("accept_timeout", 32'(got), 32'd1);
    end else begin
      cur_d.push_back(d);
      cur_b.push_back(bad);
      if (cur_d.size() == FRAME_LEN) begin
        exp_q.push_back(model_frame());
        cur_d.delete();
        cur_b.delete();
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
    cur_d.delete();
    cur_b.delete();
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_max",   32'(bus.out_max),   32'd0);
    chk("rst_out_idx",   32'(bus.out_idx),   32'd0);
    chk("rst_out_ties",  32'(bus.out_ties),  32'd0);
    chk("rst_out_err",   32'(bus.out_err),   32'd0);
    chk("rst_cmp_b",     32'(bus.cmp_b),     32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every result handshake is checked against the queue head.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_max",  32'(bus.out_max),  32'(mon_e.mx));
        chk("out_idx",  32'(bus.out_idx),  32'(mon_e.idx));
        chk("out_ties", 32'(bus.out_ties), 32'(mon_e.ties));
        chk("out_err",  32'(bus.out_err),  32'(mon_e.err));
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    force_bad    = 1'b0;
    bad_code     = '0;
    rand_ready   = 1'b0;
    ready_val    = 1'b1;
    do_reset(2);

    // Ties, with latency check on out_valid / in_ready.
    send(8'd3, 0, 0); send(8'd7, 0, 0); send(8'd7, 0, 0); send(8'd2, 0, 0);
    @(negedge clk);
    chk("lat_out_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_in_ready",  32'(bus.in_ready),  32'd0);
    @(posedge clk); #1;

    // Maximum on the first sample.
    send(8'hFF, 0, 0); send(8'h00, 0, 0); send(8'h00, 0, 0); send(8'hFF, 0, 0);
    @(posedge clk); #1;

    // Backpressure: five HOLD cycles with a new sample waiting.
    ready_val = 1'b0;
    send(8'd10, 0, 0); send(8'd20, 0, 0); send(8'd30, 0, 0); send(8'd40, 0, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_out_max",   32'(bus.out_max),   32'd40);
      chk("bp_out_idx",   32'(bus.out_idx),   32'd3);
      chk("bp_out_ties",  32'(bus.out_ties),  32'd1);
    end
    @(posedge clk); #1;
    ready_val = 1'b1;
    send(8'd9, 0, 0);
    @(negedge clk);
    chk("bp_cmp_b_after", 32'(bus.cmp_b), 32'd9);
    @(posedge clk); #1;
    send(8'd1, 0, 0); send(8'd2, 0, 0); send(8'd3, 0, 0);
    @(posedge clk); #1;

    // Reset mid-frame discards the partial frame.
    send(8'd50, 0, 0); send(8'd60, 0, 0);
    do_reset(1);
    send(8'd1, 0, 0); send(8'd2, 0, 0); send(8'd3, 0, 0); send(8'd4, 0, 0);
    @(posedge clk); #1;

    // Illegal flags on the second sample, then a clean frame.
    send(8'd5, 0, 0); send(8'd6, 1, 3'b101); send(8'd7, 0, 0); send(8'd8, 0, 0);
    @(posedge clk); #1;
    send(8'd4, 0, 0); send(8'd4, 0, 0); send(8'd1, 0, 0); send(8'd4, 0, 0);
    @(posedge clk); #1;

    // Random frames with random gaps, consumer stalls and flag corruption.
    rand_ready = 1'b1;
    for (int f = 0; f < 40 * FRAME_LEN; f++) begin
      logic [7:0] d;
      logic       b;
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      d = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
      b = ($urandom_range(0, 7) == 0);
      send(d, b, bad_codes[$urandom_range(0, 4)]);
    end

    // Drain outstanding results.
    rand_ready = 1'b0;
    ready_val  = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/frame_max_tracker.md
# frame_max_tracker

Streaming stage directly downstream of `eight_bit_comparator`. It accepts a stream of 8-bit samples over a valid/ready handshake and presents each sample to an external comparator instance, with the stored running maximum on the other input. It consumes the comparator's `less`/`equal`/`greater` flags to track the frame maximum, the index of the maximum's first occurrence, and its tie count. At the end of each fixed-length frame it emits one result over a valid/ready output handshake.

## Interface
- `FRAME_LEN`, default 8: samples per frame; legal range 2..255.
- `IDX_W`, default 3: index width; must equal clog2(FRAME_LEN).
- `CNT_W`, default 4: tie-count width; must equal clog2(FRAME_LEN+1).

Ports:
- `clk`  in  1  rising-edge clock; the block has one clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  sample present on `in_data`.
- `in_ready`  out  1  block can accept a sample this cycle.
- `in_data`  in  8  unsigned sample.
- `cmp_a`  out  8  to comparator A; always equals `in_data`.
- `cmp_b`  out  8  to comparator B; always equals the `max_r` register.
- `cmp_less`, `cmp_equal`, `cmp_greater`  in  1 each  comparator flags for A vs B; combinational, same cycle.
- `out_valid`  out  1  frame result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_max`  out  8  frame maximum.
- `out_idx`  out  IDX_W  position (0-based) of the first occurrence of the maximum.
- `out_ties`  out  CNT_W  number of samples equal to the maximum (≥1).
- `out_err`  out  1  at least one illegal flag encoding was seen in this frame.

## Operation
- A sample is accepted on a cycle where `in_valid && in_ready` is sampled at the rising edge.
- Registers: `max_r`, `idx_r`, `ties_r`, `err_r`, and `pos_r` (0..FRAME_LEN-1).
- The state machine has three states: FIRST, ACCUM and HOLD.
- FIRST (reset state):
  - `in_ready` = 1.
  - On accept: `max_r`=`in_data`, `idx_r`=0, `ties_r`=1, `err_r`=0, `pos_r`=1, then go to ACCUM.
  - Comparator flags are ignored in this state.
- ACCUM:
  - `in_ready` = 1.
  - On accept, flags are decoded from `{less,equal,greater}`:
    - 001 (greater): `max_r`=`in_data`, `idx_r`=`pos_r`, `ties_r`=1.
    - 010 (equal): `ties_r`+=1.
    - 100 (less): no update.
    - Any other encoding: no update, and `err_r` is set (sticky until the next FIRST accept).
  - Every accept increments `pos_r`.
  - On the accept where `pos_r`==FRAME_LEN-1, the update above is applied and the state goes to HOLD.
- HOLD:
  - `in_ready` = 0 and `out_valid` = 1.
  - `out_*` are driven from the registers and stay stable until the handshake.
  - On `out_ready`=1: go to FIRST and clear `pos_r`.
- `out_max`/`out_idx`/`out_ties`/`out_err` are registers. Their values outside HOLD are don't-care for consumers, but they are held at their last value (0 after reset).
- `ties_r` cannot overflow: it is at most FRAME_LEN, which CNT_W is sized to hold.

## Timing
- Reset (synchronous, takes effect at the clock edge with `reset`=1):
  - State goes to FIRST.
  - `max_r`, `idx_r`, `ties_r`, `err_r`, `pos_r` = 0.
  - Outputs after reset: `out_valid`=0, `in_ready`=1, `out_max`=0, `out_idx`=0, `out_ties`=0, `out_err`=0.
- Reset mid-frame discards the partial frame. Reset during HOLD drops the pending result.
- Throughput is one sample per cycle within a frame.
- Latency: `out_valid` rises the cycle after the last sample of the frame is accepted.
- Each frame costs at least one HOLD cycle. If `out_ready` is already high, the next frame's first sample can be accepted in the cycle after the output handshake.
- `in_ready` drops in the same cycle HOLD is entered. `in_valid` during HOLD is not consumed, and the data must be held by the producer.
- `reset` has priority over every handshake in the same cycle.
- The comparator path is combinational: `in_data` → `cmp_a` → flags → register next-state, all within one cycle. `cmp_b` changes only on clock edges.

## Test plan
- Reset check:
  - Stimulus: reset high for 2 cycles.
  - Required: `out_valid`=0, `in_ready`=1, all `out_*`=0, `cmp_b`=0.
- Tie tracking (FRAME_LEN=4):
  - Stimulus: frame 3, 7, 7, 2, back-to-back, with `out_ready`=1.
  - Required: one cycle after the 4th accept, `out_valid`=1 with `out_max`=7, `out_idx`=1, `out_ties`=2, `out_err`=0.
- Maximum on the first sample (FRAME_LEN=4):
  - Stimulus: frame 8'hFF, 0, 0, 8'hFF.
  - Required: `out_max`=FF, `out_idx`=0, `out_ties`=2.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 5 cycles of HOLD, with `in_valid`=1 presenting 9.
  - Required: `in_ready`=0 throughout and outputs stable. After `out_ready` pulses, 9 is accepted on the next cycle as sample 0 of the new frame (`cmp_b` irrelevant, `max_r`=9).
- Reset mid-frame (FRAME_LEN=4):
  - Stimulus: accept 50, 60, then reset for 1 cycle, then frame 1, 2, 3, 4.
  - Required: `out_max`=4, `out_idx`=3, `out_ties`=1.
- Illegal flag encoding (FRAME_LEN=4):
  - Stimulus: frame 5, 6, 7, 8, with the bench forcing `cmp_less`=`cmp_greater`=1 on the 2nd sample.
  - Required: `out_max`=8, `out_idx`=3, `out_ties`=1, `out_err`=1.
  - Required: the next clean frame reports `out_err`=0.
